// File: rtl/df_ctrl_pkg.sv
// df_ctrl_pkg: shared process-state type, counter width default and token-width helper for df_chain_ctrl
package df_ctrl_pkg;
    typedef enum logic [1:0] {P_WAIT = 2'd0, P_BUSY = 2'd1, P_HOLD = 2'd2} proc_state_t;
    localparam int DF_CNT_W = 32;
    function automatic int tok_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/df_chain_ctrl_chan.sv
// df_chan_token: occupancy counter for one inter-process channel
// Ports: i_clk/i_rst clock and sync reset; i_inc producer token, i_dec consumer token;
//        o_full/o_empty occupancy flags; o_err over/underflow attempt (count is left unchanged).
module df_chan_token
    import df_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_empty,
    output logic o_err
);
    localparam int TW = tok_w(DEPTH);
    logic [TW-1:0] r_occ;
    logic w_up, w_dn;
    assign o_full  = r_occ == TW'(DEPTH);
    assign o_empty = r_occ == '0;
    assign w_up    = i_inc & ~i_dec;
    assign w_dn    = i_dec & ~i_inc;
    assign o_err   = (w_up & o_full) | (w_dn & o_empty);
    always_ff @(posedge i_clk) begin
        if (i_rst) r_occ <= '0;
        else if (w_up & ~o_full) r_occ <= r_occ + TW'(1);
        else if (w_dn & ~o_empty) r_occ <= r_occ - TW'(1);
    end
endmodule

// File: rtl/df_chain_ctrl.sv
// df_chain_ctrl: dataflow chain controller generating per-process ap_start/ap_continue from channel tokens
// Ports: ap_clk/ap_rst clock and sync reset; ap_start/ap_continue/ap_ready/ap_done/ap_idle block handshake;
//        proc_start/proc_continue out and proc_ready/proc_done/proc_idle in per process;
//        iter_cnt completed iterations; proto_err sticky violation flag; stall_cnt per-process hold cycles.
// Macro DF_STALL_CNT_EN builds the saturating stall counters; otherwise stall_cnt is tied to 0.
module df_chain_ctrl
    import df_ctrl_pkg::*;
#(
    parameter int NPROC      = 5,
    parameter int CHAN_DEPTH = 2,
    parameter int CNT_W      = DF_CNT_W
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   ap_start,
    input  logic                   ap_continue,
    output logic                   ap_ready,
    output logic                   ap_done,
    output logic                   ap_idle,
    output logic [NPROC-1:0]       proc_start,
    output logic [NPROC-1:0]       proc_continue,
    input  logic [NPROC-1:0]       proc_ready,
    input  logic [NPROC-1:0]       proc_done,
    input  logic [NPROC-1:0]       proc_idle,
    output logic [CNT_W-1:0]       iter_cnt,
    output logic                   proto_err,
    output logic [NPROC*CNT_W-1:0] stall_cnt
);
    logic [NPROC-2:0] w_full, w_empty, w_inc, w_dec, w_cerr;
    proc_state_t r_st [NPROC];
    proc_state_t w_nxt [NPROC];
    logic w_perr, w_all_wait, r_err;
    logic [CNT_W-1:0] r_iter;
    // Starts and continues depend only on registered occupancy, so a token is never bypassed within a cycle.
    assign proc_start    = ap_rst ? '0 : {~w_empty, ap_start};
    assign proc_continue = ap_rst ? '0 : {ap_continue, ~w_full};
    assign ap_ready      = proc_start[0] & proc_ready[0];
    assign ap_done       = ~ap_rst & proc_done[NPROC-1];
    assign ap_idle       = ap_rst | ((&proc_idle) & (&w_empty) & w_all_wait);
    assign w_inc         = proc_done[NPROC-2:0] & proc_continue[NPROC-2:0];
    assign w_dec         = proc_start[NPROC-1:1] & proc_ready[NPROC-1:1];
    assign iter_cnt      = r_iter;
    assign proto_err     = r_err;
    genvar c;
    for (c = 0; c < NPROC - 1; c++) begin : g_chan
        df_chan_token #(.DEPTH(CHAN_DEPTH)) u_tok (
            .i_clk  (ap_clk),
            .i_rst  (ap_rst),
            .i_inc  (w_inc[c]),
            .i_dec  (w_dec[c]),
            .o_full (w_full[c]),
            .o_empty(w_empty[c]),
            .o_err  (w_cerr[c])
        );
    end
    always_comb begin
        w_perr     = |w_cerr;
        w_all_wait = 1'b1;
        for (int i = 0; i < NPROC; i++) begin
            w_nxt[i]   = r_st[i];
            w_all_wait = w_all_wait & (r_st[i] == P_WAIT);
            case (r_st[i])
                P_WAIT: begin
                    w_perr = w_perr | proc_done[i];
                    if (proc_start[i] & proc_ready[i]) w_nxt[i] = P_BUSY;
                end
                P_BUSY: if (proc_done[i]) w_nxt[i] = proc_continue[i] ? P_WAIT : P_HOLD;
                P_HOLD: begin
                    // a held done must stay asserted until it is accepted
                    w_perr = w_perr | ~proc_done[i];
                    if (proc_continue[i]) w_nxt[i] = P_WAIT;
                end
                default: w_nxt[i] = P_WAIT;
            endcase
        end
    end
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_st   <= '{default: P_WAIT};
            r_err  <= 1'b0;
            r_iter <= '0;
        end else begin
            r_st  <= w_nxt;
            r_err <= r_err | w_perr;
            if (ap_done & ap_continue) r_iter <= r_iter + CNT_W'(1);
        end
    end
`ifdef DF_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall [NPROC];
    always_ff @(posedge ap_clk) begin
        for (int i = 0; i < NPROC; i++) begin
            if (ap_rst) r_stall[i] <= '0;
            else if ((r_st[i] == P_HOLD) && ~&r_stall[i]) r_stall[i] <= r_stall[i] + CNT_W'(1);
        end
    end
    genvar s;
    for (s = 0; s < NPROC; s++) begin : g_stall
        assign stall_cnt[s*CNT_W +: CNT_W] = r_stall[s];
    end
`else
    assign stall_cnt = '0;
`endif
endmodule
